// File: rtl/imem_loader.sv
// Instruction-memory loader: parses a framed byte stream (MAGIC, LEN, payload, CSUM),
// writes little-endian 32-bit words into instruction memory and holds the core until a frame verifies.
module imem_loader #(
    parameter int          ADDR_WIDTH     = 10,
    parameter int          BASE_WORD      = 0,
    parameter logic [7:0]  MAGIC          = 8'hA5,
    parameter int          TIMEOUT_CYCLES = 1000000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  cpu_hold,
    output logic                  load_done,
    output logic                  load_err,
    output logic [15:0]           words_loaded
);

    typedef enum logic [2:0] {
        S_IDLE, S_LEN0, S_LEN1, S_DATA, S_CSUM, S_DONE, S_ERR
    } state_t;

    localparam int                    TW        = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0]         TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [ADDR_WIDTH-1:0] BASE_ADDR = ADDR_WIDTH'(BASE_WORD);
    localparam logic [32:0]           CAPACITY  = 33'd1 << ADDR_WIDTH;

    state_t         state, state_nxt;
    logic           accept;
    logic           is_magic;
    logic [15:0]    len;
    logic [15:0]    len_rx;
    logic [23:0]    word_sr;
    logic [1:0]     byte_idx;
    logic [7:0]     checksum;
    logic [TW-1:0]  tmo_cnt;
    logic           timer_active;
    logic           tmo_expired;
    logic           last_word;

    assign accept       = in_valid && in_ready;
    assign is_magic     = (in_data == MAGIC);
    assign len_rx       = {in_data, len[7:0]};
    assign timer_active = (state == S_LEN0) || (state == S_LEN1) ||
                          (state == S_DATA) || (state == S_CSUM);
    assign tmo_expired  = timer_active && !accept && (tmo_cnt == TMO_LAST);
    assign last_word    = (words_loaded == len - 16'd1);

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // NOTE: the default assignment first keeps every path driven, so no latch is inferred.
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE, S_ERR: if (accept && is_magic) state_nxt = S_LEN0;
            S_LEN0: if (accept) state_nxt = S_LEN1;
            S_LEN1: begin
                if (accept) begin
                    if ({17'd0, len_rx} > CAPACITY) state_nxt = S_ERR;
                    else if (len_rx == 16'd0)      state_nxt = S_CSUM;
                    else                           state_nxt = S_DATA;
                end
            end
            S_DATA: if (accept && byte_idx == 2'd3 && last_word) state_nxt = S_CSUM;
            S_CSUM: if (accept) state_nxt = (in_data == checksum) ? S_DONE : S_ERR;
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (tmo_expired) state_nxt = S_ERR;
    end

    always_comb begin
        in_ready  = (state != S_DONE);
        cpu_hold  = (state != S_IDLE) && (state != S_DONE);
        load_done = (state == S_DONE);
        load_err  = (state == S_ERR);
    end

    // Datapath: word assembly, checksum, write port, inter-byte timer.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            words_loaded <= '0;
            len          <= '0;
            word_sr      <= '0;
            byte_idx     <= '0;
            checksum     <= '0;
            tmo_cnt      <= '0;
        end else begin
            mem_we  <= 1'b0;
            tmo_cnt <= (!timer_active || accept) ? '0 : tmo_cnt + 1'b1;
            unique case (state)
                S_IDLE, S_ERR: begin
                    if (accept && is_magic) begin
                        words_loaded <= '0;
                        checksum     <= '0;
                        byte_idx     <= '0;
                    end
                end
                S_LEN0: if (accept) len[7:0]  <= in_data;
                S_LEN1: if (accept) len[15:8] <= in_data;
                S_DATA: begin
                    if (accept) begin
                        word_sr  <= {in_data, word_sr[23:8]};
                        checksum <= checksum ^ in_data;
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) begin
                            mem_we       <= 1'b1;
                            mem_addr     <= BASE_ADDR + ADDR_WIDTH'(words_loaded);
                            mem_wdata    <= {in_data, word_sr};
                            words_loaded <= words_loaded + 16'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader (ADDR_WIDTH=4, TIMEOUT_CYCLES=16): stimulus pushes expected
// writes into a queue, a monitor pops and compares each mem_we pulse.
module tb_imem_loader;

    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic [7:0]    in_data;
    logic          in_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          cpu_hold;
    logic          load_done;
    logic          load_err;
    logic [15:0]   words_loaded;

    imem_loader #(
        .ADDR_WIDTH(AW), .BASE_WORD(0), .MAGIC(8'hA5), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .cpu_hold(cpu_hold), .load_done(load_done),
        .load_err(load_err), .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    wr_t exp_q[$];
    int  n_compared = 0;
    int  n_mismatch = 0;
    int  we_count   = 0;
    int  done_count = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatch++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: outputs are sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (load_done) done_count++;
        if (mem_we === 1'b1) begin
            we_count++;
            if (exp_q.size() == 0) begin
                n_compared++;
                n_mismatch++;
                $display("FAIL unexpected_write: got addr %0d data 0x%08h, expected no write",
                         mem_addr, mem_wdata);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_addr", 32'(mem_addr), 32'(e.addr));
                check("wr_data", mem_wdata, e.data);
            end
        end
    end

    // Drives at the falling edge; returns at the falling edge after the byte was accepted.
    task automatic send_byte(input logic [7:0] b, input int gap);
        logic rdy;
        for (int i = 0; i < gap; i++) begin
            in_valid = 1'b0;
            @(negedge clk);
        end
        in_valid = 1'b1;
        in_data  = b;
        for (int t = 0; t < 20; t++) begin
            rdy = in_ready;
            @(negedge clk);
            if (rdy) return;
        end
        check("send_byte_ready_timeout", 32'(in_ready), 32'd1);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic push_exp(input int addr, input logic [31:0] data);
        wr_t e;
        e.addr = AW'(addr);
        e.data = data;
        exp_q.push_back(e);
    endtask

    // Frame A: two words, payload XOR = 0x90.
    logic [7:0] frame_a [12] = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                                 8'h93, 8'h00, 8'h10, 8'h00, 8'h90};

    task automatic send_frame_a(input logic [7:0] csum, input int max_gap);
        for (int i = 0; i < 11; i++) send_byte(frame_a[i], (max_gap > 0) ? $urandom_range(0, max_gap) : 0);
        send_byte(csum, (max_gap > 0) ? $urandom_range(0, max_gap) : 0);
    endtask

    initial begin
        int d0, w0, k;
        logic [7:0]  cs;
        logic [31:0] w;

        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_cpu_hold", 32'(cpu_hold), 32'd0);
        check("rst_load_err", 32'(load_err), 32'd0);
        check("rst_load_done", 32'(load_done), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_words_loaded", 32'(words_loaded), 32'd0);

        // Good two-word frame, in_valid held high.
        d0 = done_count;
        push_exp(0, 32'h0000_0013);
        push_exp(1, 32'h0010_0093);
        send_byte(8'hA5, 0);
        check("a_hold_after_magic", 32'(cpu_hold), 32'd1);
        for (int i = 1; i < 12; i++) send_byte(frame_a[i], 0);
        idle(4);
        check("a_done_pulses", 32'(done_count - d0), 32'd1);
        check("a_words_loaded", 32'(words_loaded), 32'd2);
        check("a_cpu_hold", 32'(cpu_hold), 32'd0);
        check("a_load_err", 32'(load_err), 32'd0);

        // Bad checksum: writes still happen, error is sticky.
        push_exp(0, 32'h0000_0013);
        push_exp(1, 32'h0010_0093);
        send_frame_a(8'h91, 0);
        idle(3);
        check("b_load_err", 32'(load_err), 32'd1);
        check("b_cpu_hold", 32'(cpu_hold), 32'd1);
        idle(20);
        check("b_err_sticky", 32'(load_err), 32'd1);
        check("b_hold_sticky", 32'(cpu_hold), 32'd1);
        d0 = done_count;
        send_byte(8'hA5, 0); send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
        idle(3);
        check("b_recover_err", 32'(load_err), 32'd0);
        check("b_recover_done", 32'(done_count - d0), 32'd1);
        check("b_recover_hold", 32'(cpu_hold), 32'd0);

        // Garbage then empty frame.
        d0 = done_count;
        w0 = we_count;
        send_byte(8'h00, 0); send_byte(8'hFF, 0); send_byte(8'h12, 0);
        idle(2);
        check("garbage_hold", 32'(cpu_hold), 32'd0);
        send_byte(8'hA5, 0); send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
        idle(3);
        check("empty_done", 32'(done_count - d0), 32'd1);
        check("empty_no_we", 32'(we_count - w0), 32'd0);
        check("empty_words", 32'(words_loaded), 32'd0);

        // Timeout mid-word: error 16 cycles after the last accepted byte.
        w0 = we_count;
        send_byte(8'hA5, 0); send_byte(8'h01, 0); send_byte(8'h00, 0); send_byte(8'h13, 0);
        in_valid = 1'b0;
        k = 0;
        while (!load_err && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("tmo_latency", 32'(k), 32'd16);
        check("tmo_hold", 32'(cpu_hold), 32'd1);
        check("tmo_no_we", 32'(we_count - w0), 32'd0);

        // Oversized frame (17 > 16 words), restarted from ERR.
        send_byte(8'hA5, 0);
        check("big_magic_clears_err", 32'(load_err), 32'd0);
        send_byte(8'h11, 0); send_byte(8'h00, 0);
        check("big_err_now", 32'(load_err), 32'd1);

        // Full-capacity frame: 16 words at addr 0..15.
        d0 = done_count;
        cs = 8'h00;
        send_byte(8'hA5, 0); send_byte(8'h10, 0); send_byte(8'h00, 0);
        for (int i = 0; i < 16; i++) begin
            w = {8'(i), 8'hA0, 8'(i * 3), 8'h5A};
            push_exp(i, w);
            for (int b = 0; b < 4; b++) begin
                cs = cs ^ w[8*b +: 8];
                send_byte(w[8*b +: 8], 0);
            end
        end
        send_byte(cs, 0);
        idle(3);
        check("full_done", 32'(done_count - d0), 32'd1);
        check("full_err", 32'(load_err), 32'd0);
        check("full_words", 32'(words_loaded), 32'd16);

        // Frame A with random gaps below the timeout.
        d0 = done_count;
        push_exp(0, 32'h0000_0013);
        push_exp(1, 32'h0010_0093);
        send_frame_a(8'h90, 10);
        idle(3);
        check("gap_done", 32'(done_count - d0), 32'd1);
        check("gap_hold", 32'(cpu_hold), 32'd0);

        // Reset after the 6th payload byte: only the first word is written.
        w0 = we_count;
        push_exp(0, 32'h0000_0013);
        for (int i = 0; i < 9; i++) send_byte(frame_a[i], 0);
        in_valid = 1'b0;
        reset    = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rstmid_hold", 32'(cpu_hold), 32'd0);
        check("rstmid_ready", 32'(in_ready), 32'd1);
        check("rstmid_we", 32'(mem_we), 32'd0);
        idle(20);
        check("rstmid_we_total", 32'(we_count - w0), 32'd1);
        check("rstmid_err", 32'(load_err), 32'd0);

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
        $finish;
    end

endmodule
